// File: rtl/main_memory_pkg.sv
// main_memory_pkg: shared constants for the cache/memory visit interface.
//   mem_vis_e      - 2-bit visit code driven by the cache each cycle
//   IO_*_OFFSET    - byte offsets inside the MMIO window above IO_BASE
package main_memory_pkg;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        READ_INST = 2'd1,
        READ_DATA = 2'd2,
        WRITE     = 2'd3
    } mem_vis_e;

    localparam int unsigned IO_PORT_OFFSET = 0;  // W: push to output FIFO, R: fifo count
    localparam int unsigned IO_FULL_OFFSET = 1;  // R: fifo full flag
    localparam int unsigned IO_HALT_OFFSET = 4;  // W: set halt, R: halt flag

endpackage

// File: rtl/main_memory_byte_fifo.sv
// byte_fifo: small synchronous FIFO, head visible combinationally.
//   push/push_data - enqueue; dropped when full unless a pop frees a slot
//   pop            - dequeue; ignored when empty
//   head           - entry at read pointer (undefined content when empty)
//   count          - occupancy, log2(DEPTH)+1 bits
//   full/empty     - occupancy flags
module byte_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign head  = store_q[rd_ptr_q];

    // A pop in the same cycle frees the slot the push needs when full.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) store_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/main_memory.sv
module main_memory
    import main_memory_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 17,
    parameter int unsigned            BYTE_SIZE  = 8,
    parameter logic [ADDR_WIDTH-1:0]  IO_BASE    = 17'h1FFF0,
    parameter int unsigned            FIFO_DEPTH = 8,
    parameter                         INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mem_vis_addr,
    input  logic [BYTE_SIZE-1:0]  mem_writen_data,
    input  logic [1:0]            mem_vis_signal,
    output logic [BYTE_SIZE-1:0]  mem_data,
    output logic [BYTE_SIZE-1:0]  io_out_data,
    output logic                  io_out_valid,
    input  logic                  io_out_ready,
    output logic                  halt,
    output logic                  io_overflow
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [BYTE_SIZE-1:0]  ram_q [0:IO_BASE-1];
    logic [BYTE_SIZE-1:0]  mem_data_q, rd_byte, io_rd_byte;
    logic                  halt_q, overflow_q;
    mem_vis_e              vis;
    logic                  is_io, is_read, is_write;
    logic [ADDR_WIDTH-1:0] io_off;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    assign vis      = mem_vis_e'(mem_vis_signal);
    assign is_read  = (vis == READ_INST) || (vis == READ_DATA);
    assign is_write = (vis == WRITE);
    assign is_io    = (mem_vis_addr >= IO_BASE);
    assign io_off   = mem_vis_addr - IO_BASE;

    assign fifo_push = is_write && is_io && (io_off == ADDR_WIDTH'(IO_PORT_OFFSET));
    assign fifo_pop  = io_out_valid && io_out_ready;

    always_comb begin
        io_rd_byte = '0;
        if (io_off == ADDR_WIDTH'(IO_PORT_OFFSET))      io_rd_byte = BYTE_SIZE'(fifo_count);
        else if (io_off == ADDR_WIDTH'(IO_FULL_OFFSET)) io_rd_byte = BYTE_SIZE'(fifo_full);
        else if (io_off == ADDR_WIDTH'(IO_HALT_OFFSET)) io_rd_byte = BYTE_SIZE'(halt_q);
    end

    // Writes also return the pre-write contents, so one read path serves both.
    assign rd_byte = is_io ? io_rd_byte : ram_q[mem_vis_addr];

    always_ff @(posedge clk) begin
        if (is_write && !is_io) ram_q[mem_vis_addr] <= mem_writen_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_data_q <= '0;
            halt_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (is_read || is_write) mem_data_q <= rd_byte;
            if (is_write && is_io && (io_off == ADDR_WIDTH'(IO_HALT_OFFSET)))
                halt_q <= 1'b1;
            if (fifo_push && fifo_full && !fifo_pop)
                overflow_q <= 1'b1;
        end
    end

    byte_fifo #(
        .WIDTH (BYTE_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (mem_writen_data),
        .pop       (fifo_pop),
        .head      (io_out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign mem_data     = mem_data_q;
    assign io_out_valid = !fifo_empty;
    assign halt         = halt_q;
    assign io_overflow  = overflow_q;

endmodule
